// File: rtl/execute.sv
// Shared execute-stage types used by the memory path.
package execute;

   typedef logic [1:0] memory_access_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving the CPU core (m0) and a secondary master (m1)
// exclusive use of the single memory port, with a per-transaction watchdog.
module mem_bus_arbiter
   import execute::*;
#(
   parameter int XLEN     = 32,
   parameter int PLEN     = 34,
   parameter int MAX_WAIT = 255
) (
   input  logic                      clock,
   input  logic                      reset_n,

   input  logic                      m0_cycle,
   input  logic [PLEN-1:0]           m0_paddr,
   input  memory_access_t            m0_access,
   input  logic [XLEN-1:0]           m0_data_out,
   output logic [3:0][XLEN-1:0]      m0_data_in,
   output logic                      m0_ack,
   output logic                      m0_error,

   input  logic                      m1_cycle,
   input  logic [PLEN-1:0]           m1_paddr,
   input  memory_access_t            m1_access,
   input  logic [XLEN-1:0]           m1_data_out,
   output logic [3:0][XLEN-1:0]      m1_data_in,
   output logic                      m1_ack,
   output logic                      m1_error,

   output logic                      mem_cycle,
   output logic [PLEN-1:0]           mem_paddr,
   output memory_access_t            mem_access,
   output logic [XLEN-1:0]           mem_data_out,
   input  logic [3:0][XLEN-1:0]      mem_data_in,
   input  logic                      mem_ack,

   output logic                      busy,
   output logic [7:0]                timeout_count,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam logic [15:0] LAST_WAIT = 16'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [15:0] wait_q, wait_d;
   logic [7:0]  tcount_q, tcount_d;

   logic        in_grant;
   logic        own_cycle;
   logic        grant_ack;
   logic        grant_to;

   always_comb begin
      in_grant  = (state_q == GRANT0) || (state_q == GRANT1);
      own_cycle = (state_q == GRANT1) ? m1_cycle : m0_cycle;
      grant_ack = in_grant && own_cycle && mem_ack;
      // Ack on the last allowed cycle beats the watchdog.
      grant_to  = in_grant && own_cycle && !mem_ack && (wait_q == LAST_WAIT);
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      wait_d   = wait_q;
      tcount_d = tcount_q;
      unique case (state_q)
         IDLE: begin
            if (m0_cycle && (!m1_cycle || last_q)) begin
               state_d = GRANT0;
               wait_d  = 16'd0;
            end else if (m1_cycle) begin
               state_d = GRANT1;
               wait_d  = 16'd0;
            end
         end
         GRANT0, GRANT1: begin
            if (!own_cycle || grant_ack || grant_to) begin
               last_d  = (state_q == GRANT1);
               // An abort skips DRAIN since mem_cycle is already low.
               state_d = own_cycle ? DRAIN : IDLE;
            end else begin
               wait_d = wait_q + 16'd1;
            end
            if (grant_to && (tcount_q != 8'hff)) begin
               tcount_d = tcount_q + 8'd1;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         wait_q   <= 16'd0;
         tcount_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         wait_q   <= wait_d;
         tcount_q <= tcount_d;
      end
   end

   always_comb begin
      mem_cycle     = in_grant && own_cycle;
      mem_paddr     = (state_q == GRANT1) ? m1_paddr    : m0_paddr;
      mem_access    = (state_q == GRANT1) ? m1_access   : m0_access;
      mem_data_out  = (state_q == GRANT1) ? m1_data_out : m0_data_out;
      m0_data_in    = mem_data_in;
      m1_data_in    = mem_data_in;
      m0_ack        = (state_q == GRANT0) && mem_ack && m0_cycle;
      m1_ack        = (state_q == GRANT1) && mem_ack && m1_cycle;
      m0_error      = (state_q == GRANT0) && grant_to;
      m1_error      = (state_q == GRANT1) && grant_to;
      busy          = (state_q != IDLE);
      timeout_count = tcount_q;
      state_dbg     = state_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level timeline model
// predicts grants, completions and watchdog timeouts; monitors check the DUT.
module tb_mem_bus_arbiter;
   import execute::*;

   localparam int XLEN     = 32;
   localparam int PLEN     = 34;
   localparam int MAX_WAIT = 4;
   localparam int EW       = 16 + 1 + 1 + 4 * XLEN;
   localparam int MW       = PLEN + 2 + XLEN;
   localparam int SW       = 1 + 1 + 8;
   localparam logic [4*XLEN-1:0] ZD = '0;

   logic                 clock;
   logic                 reset_n;
   logic                 m0_cycle, m1_cycle;
   logic [PLEN-1:0]      m0_paddr, m1_paddr;
   memory_access_t       m0_access, m1_access;
   logic [XLEN-1:0]      m0_data_out, m1_data_out;
   logic [3:0][XLEN-1:0] m0_data_in, m1_data_in;
   logic                 m0_ack, m1_ack, m0_error, m1_error;
   logic                 mem_cycle;
   logic [PLEN-1:0]      mem_paddr;
   memory_access_t       mem_access;
   logic [XLEN-1:0]      mem_data_out;
   logic [3:0][XLEN-1:0] mem_data_in;
   logic                 mem_ack;
   logic                 busy;
   logic [7:0]           timeout_count;
   logic [1:0]           state_dbg;

   mem_bus_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_cycle(m0_cycle), .m0_paddr(m0_paddr), .m0_access(m0_access),
      .m0_data_out(m0_data_out), .m0_data_in(m0_data_in),
      .m0_ack(m0_ack), .m0_error(m0_error),
      .m1_cycle(m1_cycle), .m1_paddr(m1_paddr), .m1_access(m1_access),
      .m1_data_out(m1_data_out), .m1_data_in(m1_data_in),
      .m1_ack(m1_ack), .m1_error(m1_error),
      .mem_cycle(mem_cycle), .mem_paddr(mem_paddr), .mem_access(mem_access),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ack(mem_ack),
      .busy(busy), .timeout_count(timeout_count), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [MW-1:0] exp_mem_q[$];
   logic [SW-1:0] exp_st_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;
   bit  mon_en = 1'b0;
   logic prev_mem_cycle = 1'b0;

   // ---------------- reference model (transaction timeline) ----------------
   int              owner;
   int              gstart, gend, idle_from;
   bit              aborted, timed_out;
   bit              last;
   int              tc;
   bit [1:0]        active;
   logic [PLEN-1:0] pa [2];
   logic [1:0]      ac [2];
   logic [XLEN-1:0] wd [2];
   int p_req, p_to, p_abort, p_spur, p_rst;

   task automatic step();
      bit [1:0]             dropping;
      bit                   do_rst;
      bit                   in_grant;
      bit                   exp_busy, exp_mcyc;
      int                   w, lat, a;
      logic [63:0]          r64;
      logic [3:0][XLEN-1:0] rd;

      if (owner != -1 && cyc >= idle_from) owner = -1;
      dropping = 2'b00;
      if (owner != -1) begin
         if ((!aborted && cyc == gend + 1) || (aborted && cyc == gend)) begin
            active[owner]   = 1'b0;
            dropping[owner] = 1'b1;
         end
      end
      do_rst = (owner == 1) && (cyc == gstart) && (gend > gstart) &&
               ($urandom_range(99) < p_rst);

      for (int n = 0; n < 2; n++) begin
         if (!active[n] && !dropping[n] &&
             ($urandom_range(99) < p_req || (do_rst && n == 0))) begin
            active[n] = 1'b1;
            r64   = {$urandom(), $urandom()};
            pa[n] = r64[PLEN-1:0];
            ac[n] = 2'($urandom_range(3, 0));
            wd[n] = $urandom();
         end
      end

      // Arbitration: a free bus sampled this cycle grants next cycle.
      if (owner == -1 && active != 2'b00) begin
         w         = (active == 2'b11) ? (last ? 0 : 1) : (active[0] ? 0 : 1);
         owner     = w;
         gstart    = cyc + 1;
         timed_out = $urandom_range(99) < p_to;
         lat       = timed_out ? MAX_WAIT : int'($urandom_range(MAX_WAIT, 1));
         gend      = gstart + lat - 1;
         aborted   = $urandom_range(99) < p_abort;
         if (aborted) begin
            a = timed_out ? int'($urandom_range(MAX_WAIT, 1)) :
                (lat > 1 ? int'($urandom_range(lat - 1, 1)) : 0);
            if (a == 0) aborted = 1'b0;
            else begin
               gend      = gstart + a - 1;
               timed_out = 1'b0;
            end
         end
         idle_from = aborted ? gend + 1 : gend + 2;
         if (!(aborted && gend == gstart))
            exp_mem_q.push_back({pa[w], ac[w], wd[w]});
      end

      in_grant = (owner != -1) && cyc >= gstart && cyc <= gend;
      for (int i = 0; i < 4; i++) rd[i] = $urandom();

      m0_cycle    = active[0];
      m0_paddr    = pa[0];
      m0_access   = ac[0];
      m0_data_out = wd[0];
      m1_cycle    = active[1];
      m1_paddr    = pa[1];
      m1_access   = ac[1];
      m1_data_out = wd[1];
      mem_data_in = rd;
      mem_ack     = in_grant ? (!aborted && !timed_out && cyc == gend)
                             : ($urandom_range(99) < p_spur);
      reset_n     = !do_rst;

      exp_busy = (owner != -1) && cyc >= gstart;
      exp_mcyc = in_grant && !(aborted && cyc == gend);
      exp_st_q.push_back({exp_busy, exp_mcyc, 8'(tc)});

      if (in_grant && cyc == gend) begin
         if (!aborted) begin
            if (timed_out) begin
               exp_q.push_back({16'(cyc), 1'b1, 1'(owner), ZD});
               if (tc < 255) tc++;
            end else begin
               exp_q.push_back({16'(cyc), 1'b0, 1'(owner), rd});
            end
         end
         last = (owner == 1);
      end

      if (do_rst) begin
         owner     = -1;
         idle_from = cyc + 1;
         last      = 1'b1;
         tc        = 0;
      end
   endtask

   task automatic run_phase(input int ncyc, input int req, input int to,
                            input int abrt, input int spur, input int rst);
      p_req   = req;
      p_to    = to;
      p_abort = abrt;
      p_spur  = spur;
      p_rst   = rst;
      for (int k = 0; k < ncyc; k++) begin
         #1;
         step();
         @(posedge clock);
         cyc++;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic check_event(input logic [EW-1:0] act, input string nm);
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected at cycle %0d got %h", nm, cyc, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d got %h expected %h", nm, cyc, act, e);
         end
      end
   endtask

   task automatic check_status();
      logic [SW-1:0] e, a;
      a = {busy, mem_cycle, timeout_count};
      checks++;
      if (exp_st_q.size() == 0) begin
         errors++;
         $display("FAIL status no expectation at cycle %0d got %h", cyc, a);
      end else begin
         e = exp_st_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL status(busy,mem_cycle,timeout_count) cycle %0d got %h expected %h",
                     cyc, a, e);
         end
      end
      checks++;
      if (m0_data_in !== mem_data_in || m1_data_in !== mem_data_in) begin
         errors++;
         $display("FAIL data_broadcast cycle %0d got %h / %h expected %h",
                  cyc, m0_data_in, m1_data_in, mem_data_in);
      end
   endtask

   task automatic check_mem_req();
      logic [MW-1:0] e, a;
      a = {mem_paddr, mem_access, mem_data_out};
      checks++;
      if (exp_mem_q.size() == 0) begin
         errors++;
         $display("FAIL mem_request unexpected at cycle %0d got %h", cyc, a);
      end else begin
         e = exp_mem_q.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL mem_request cycle %0d got %h expected %h", cyc, a, e);
         end
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         check_status();
         if (m0_ack)   check_event({16'(cyc), 1'b0, 1'b0, m0_data_in}, "m0_ack");
         if (m1_ack)   check_event({16'(cyc), 1'b0, 1'b1, m1_data_in}, "m1_ack");
         if (m0_error) check_event({16'(cyc), 1'b1, 1'b0, ZD}, "m0_error");
         if (m1_error) check_event({16'(cyc), 1'b1, 1'b1, ZD}, "m1_error");
         if (mem_cycle === 1'b1 && !prev_mem_cycle) check_mem_req();
      end
      prev_mem_cycle <= (mem_cycle === 1'b1);
   end

   // ---------------- main sequence ----------------
   initial begin
      reset_n     = 1'b0;
      m0_cycle    = 1'b0;
      m1_cycle    = 1'b0;
      m0_paddr    = '0;
      m1_paddr    = '0;
      m0_access   = '0;
      m1_access   = '0;
      m0_data_out = '0;
      m1_data_out = '0;
      mem_data_in = '0;
      mem_ack     = 1'b0;
      owner       = -1;
      gstart      = 0;
      gend        = 0;
      idle_from   = 0;
      aborted     = 1'b0;
      timed_out   = 1'b0;
      last        = 1'b1;
      tc          = 0;
      active      = 2'b00;
      for (int n = 0; n < 2; n++) begin
         pa[n] = '0;
         ac[n] = '0;
         wd[n] = '0;
      end
      repeat (3) @(posedge clock);
      mon_en = 1'b1;

      // continuous contention, acks only: strict alternation from m0
      run_phase(300, 100, 0, 0, 0, 0);
      // mixed traffic with timeouts, aborts, spurious acks and resets
      run_phase(2500, 35, 20, 10, 10, 4);
      // timeout-heavy traffic to drive timeout_count into saturation
      run_phase(2000, 100, 95, 0, 5, 0);
      // quiet tail so outstanding requests finish
      run_phase(30, 0, 0, 0, 0, 0);
      mon_en = 1'b0;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got %0d left expected 0", exp_q.size());
      end
      checks++;
      if (exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL pending_mem_requests got %0d left expected 0", exp_mem_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
